// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit, sampled on sin_en.
// Good words land in a one-entry valid/ready buffer; bad stop bits and full-buffer arrivals pulse flags.
module serial_frame_rx #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && ready) valid_d = 1'b0;

      if (sin_en) begin
         unique case (state_q)
            StIdle: begin
               if (!sin) begin
                  state_d = StData;
                  cnt_d   = '0;
               end
            end
            StData: begin
               shift_d = {sin, shift_q[WIDTH-1:1]};
               // Counter saturates at the last bit rather than wrapping.
               if (cnt_q == LastBit) state_d = StStop;
               else cnt_d = cnt_q + CW'(1);
            end
            StStop: begin
               state_d = StIdle;
               if (sin) begin
                  // A same-edge drain frees the buffer for the new word.
                  if (!valid_q || ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule
